// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial LSB-first ALU with start/done handshake; SERIAL_ALU_OVF_EN adds an overflow output
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
`ifdef SERIAL_ALU_OVF_EN
  output logic             overflow,
`endif
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, res_q, res_d, sr_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic mode_q, mode_d, c_q, c_d, co_q, co_d, z_q, z_d, done_q, done_d;
  logic x, y, bit_r, c_n, last;
`ifdef SERIAL_ALU_OVF_EN
  logic ovf_q, ovf_d;
  assign overflow = ovf_q;
`endif
  assign busy = state_q == RUN;
  assign done = done_q;
  assign result = res_q;
  assign carry_out = co_q;
  assign zero = z_q;
  always_comb begin
    x = a_q[0];
    y = sel_q[1] ? sel_q[0] : b_q[0] ^ sel_q[0];
    bit_r = mode_q ? x ^ y ^ c_q :
            sel_q == 2'b00 ? x & b_q[0] :
            sel_q == 2'b01 ? x | b_q[0] :
            sel_q == 2'b10 ? x ^ b_q[0] : ~x;
    c_n = mode_q & ((x & y) | (x & c_q) | (y & c_q));
    last = cnt_q == CW'(WIDTH - 1);
    sr_w = {bit_r, sr_q[WIDTH-1:1]};
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sr_d = sr_q;
    res_d = res_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    mode_d = mode_q;
    c_d = c_q;
    co_d = co_q;
    z_d = z_q;
    done_d = 1'b0;
`ifdef SERIAL_ALU_OVF_EN
    ovf_d = ovf_q;
`endif
    if (state_q == IDLE && start) begin
      a_d = a;
      b_d = b;
      mode_d = mode;
      sel_d = select;
      cnt_d = '0;
      c_d = mode & (select[0] ^ select[1]);
      state_d = RUN;
    end else if (state_q == RUN) begin
      sr_d = sr_w;
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      c_d = c_n;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        res_d = sr_w;
        co_d = c_n;
        z_d = sr_w == '0;
        done_d = 1'b1;
        state_d = IDLE;
`ifdef SERIAL_ALU_OVF_EN
        ovf_d = mode_q & (c_q ^ c_n);
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sr_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      sel_q <= '0;
      mode_q <= 1'b0;
      c_q <= 1'b0;
      co_q <= 1'b0;
      z_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sr_q <= sr_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      mode_q <= mode_d;
      c_q <= c_d;
      co_q <= co_d;
      z_q <= z_d;
      done_q <= done_d;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed and randomized checks of serial_alu_seq against a behavioural model
module tb_serial_alu_seq;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, mode = 1'b0;
  logic [1:0] select = '0;
  logic [W-1:0] a = '0, b = '0, result;
  logic busy, done, carry_out, zero;
`ifdef SERIAL_ALU_OVF_EN
  logic overflow;
`endif
  int checks = 0, errors = 0;
  logic m_busy = 0, m_done = 0, m_c = 0, m_z = 0, m_ovf = 0;
  logic [W-1:0] m_res = '0;
  logic [9:0] pend = '0;
  int m_left = 0;
  always #5 clk = ~clk;
  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .select(select),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out),
`ifdef SERIAL_ALU_OVF_EN
    .overflow(overflow),
`endif
    .zero(zero)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [9:0] calc(input logic m, input logic [1:0] s, input logic [7:0] x, input logic [7:0] yi);
    logic [7:0] y;
    logic [8:0] sum;
    if (!m)
      return {2'b00, s == 0 ? x & yi : s == 1 ? x | yi : s == 2 ? x ^ yi : ~x};
    y = s == 0 ? yi : s == 1 ? ~yi : s == 2 ? 8'h00 : 8'hFF;
    sum = {1'b0, x} + {1'b0, y} + ((s == 1 || s == 2) ? 9'd1 : 9'd0);
    return {(x[7] == y[7]) && (sum[7] != x[7]), sum[8], sum[7:0]};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_c = 0; m_z = 0; m_ovf = 0; m_res = '0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          {m_ovf, m_c, m_res} = pend;
          m_z = pend[7:0] == 0;
        end
      end else if (start) begin
        pend = calc(mode, select, a, b);
        m_busy = 1;
        m_left = W;
      end
    end
  end
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("result", result, m_res);
    chk("carry_out", carry_out, m_c);
    chk("zero", zero, m_z);
`ifdef SERIAL_ALU_OVF_EN
    chk("overflow", overflow, m_ovf);
`endif
  end
  task automatic op(input logic m, input logic [1:0] s, input logic [7:0] av, input logic [7:0] bv,
                    input logic [7:0] er, input logic ec, input logic ez, input string nm);
    int lat = 0, nb = 0;
    @(negedge clk);
    mode = m; select = s; a = av; b = bv; start = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 0;
      if (done) begin
        lat = k;
        break;
      end
      nb += int'(busy);
    end
    chk({nm, "_latency"}, lat, 9);
    chk({nm, "_busy_cycles"}, nb, 8);
    chk({nm, "_result"}, result, er);
    chk({nm, "_carry"}, carry_out, ec);
    chk({nm, "_zero"}, zero, ez);
  endtask
  initial begin
    int lat;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);
    #2 rst_n = 1;
    op(1, 0, 8'hFF, 8'h01, 8'h00, 1, 1, "add_wrap");
    op(1, 1, 8'h05, 8'h07, 8'hFE, 0, 0, "sub_borrow");
    op(1, 1, 8'h07, 8'h05, 8'h02, 1, 0, "sub_noborrow");
    op(0, 2, 8'hA5, 8'h0F, 8'hAA, 0, 0, "xor");
    op(0, 3, 8'h3C, 8'h55, 8'hC3, 0, 0, "not");
    op(1, 2, 8'hFF, 8'h12, 8'h00, 1, 1, "inc_wrap");
    op(1, 3, 8'h00, 8'h34, 8'hFF, 0, 0, "dec_wrap");
`ifdef SERIAL_ALU_OVF_EN
    op(1, 0, 8'h7F, 8'h01, 8'h80, 0, 0, "add_ovf");
    chk("add_ovf_flag", overflow, 1);
    op(1, 1, 8'h80, 8'h01, 8'h7F, 1, 0, "sub_ovf");
    chk("sub_ovf_flag", overflow, 1);
`endif
    @(negedge clk);
    mode = 1; select = 0; a = 8'h10; b = 8'h01; start = 1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 0;
      if (k == 3) begin a = 8'hFF; start = 1; end
      if (k == 4) start = 0;
      if (done) begin lat = k; break; end
    end
    chk("ignore_latency", lat, 9);
    chk("ignore_result", result, 8'h11);
    @(negedge clk);
    mode = 1; select = 0; a = 8'h22; b = 8'h33; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    lat = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) lat++;
    end
    chk("abort_no_done", lat, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    #2 rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = $urandom_range(0, 2) != 0;
      mode = 1'($urandom);
      select = 2'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 0;
        #4 rst_n = 1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Multi-bit ALU built on the team's 1-bit ALU operation set (mode, 2-bit select, one A bit, one B bit per step).
- Processes WIDTH-bit operands LSB first, one bit per clock, with an internal carry flop between bits.
- Collects the output bits into a result register and reports completion through a start/done handshake.
- Sits between a control FSM or register file and the datapath; it is the sequencing end of the 1-bit ALU interface.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = logic, 1 = arithmetic
- select  input  2  operation code within mode
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result is complete
- result  output  WIDTH  final result; held until the next accepted start
- carry_out  output  1  final carry; 0 for logic ops
- zero  output  1  high when result == 0; valid with done, held with result

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, result, carry_out and zero are all cleared to 0.
  - Shift registers, bit counter and carry flop are cleared.
  - Release of reset is synchronous to clk.
- Operations:
  - mode=0: 00 AND, 01 OR, 10 XOR, 11 NOT A (b ignored).
  - mode=1, carry-in at bit 0 given in brackets:
    - 00 ADD a+b [cin 0]
    - 01 SUB a+~b [cin 1]
    - 10 INC a+0 [cin 1]
    - 11 DEC a+all-ones [cin 0]
  - Per arithmetic bit: sum = x^y^c and c_next = majority(x,y,c), where x is the A bit and y is the effective B bit.
- FSM states: IDLE, RUN.
  - IDLE, start=1 at an edge:
    - Latch a, b, mode and select.
    - Clear the bit counter.
    - Load the carry flop with cin (0 for logic ops).
    - Go to RUN; busy=1 from the next cycle.
  - RUN, each edge:
    - Compute the bit from operand bit [0] of the shifted copies.
    - Shift it into result_sr at the MSB end; shift the operands right.
    - Update carry; increment the counter.
  - RUN, after the WIDTH-th bit edge:
    - Copy result_sr to result; copy the final carry to carry_out (forced to 0 for logic); update zero.
    - Pulse done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: start sampled at edge E0 gives done high in the cycle after edge E0+WIDTH. That is WIDTH+1 cycles from start to done, and result is valid in the same cycle as done.
- Back-to-back requests:
  - start held high is re-accepted in the done cycle itself (the FSM is IDLE then).
  - Peak throughput is one op per WIDTH+1 cycles.
- Boundary conditions:
  - start while busy is ignored; latched operands are unaffected and no request is queued.
  - Input changes during RUN have no effect.
  - result, carry_out and zero keep the previous op's values through the next op until its done.
  - Reset mid-RUN aborts the op: all outputs go to 0 and no done is produced.
  - Carry wraps naturally. ADD overflow and INC 0xFF both give result 0 with carry_out=1. SUB: carry_out=1 means no borrow.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- SERIAL_ALU_OVF_EN defined:
  - Adds output port overflow (1 bit), reset 0.
  - Updated with done: set to carry-into-MSB XOR carry-out-of-MSB for mode=1; 0 for mode=0.
  - Held with result.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, mode=1 sel=00, a=0xFF b=0x01, start one cycle -> busy for 8 cycles, done pulse 9 cycles after start, result=0x00, carry_out=1, zero=1.
- mode=1 sel=01, a=0x05 b=0x07 -> result=0xFE, carry_out=0, zero=0. Then a=0x07 b=0x05 -> result=0x02, carry_out=1.
- mode=0 sel=10, a=0xA5 b=0x0F -> result=0xAA, carry_out=0. Then sel=11, a=0x3C -> result=0xC3.
- mode=1 sel=10, a=0xFF -> result=0x00, carry_out=1. Then sel=11, a=0x00 -> result=0xFF, carry_out=0.
- Start ADD 0x10+0x01, pulse start again 3 cycles later with a=0xFF -> ignored; result=0x11. Then rst_n low at RUN bit 4 -> busy=0, result=0, no done pulse.
- With SERIAL_ALU_OVF_EN: ADD 0x7F+0x01 -> result=0x80, overflow=1, carry_out=0. SUB 0x80-0x01 -> result=0x7F, overflow=1.
